// File: rtl/frame_config_sequencer_if.sv
// ----------------------------------------------------------------------------
// frame_config_sequencer_if
// Word-stream handshake between a bitstream source and the frame sequencer.
//   s_data   source -> sink   stream word
//   s_valid  source -> sink   s_data is valid
//   s_ready  sink -> source   sink accepts; a word moves when s_valid && s_ready
// Modports: master = bitstream source, slave = sequencer.
// ----------------------------------------------------------------------------
interface frame_config_sequencer_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/frame_config_sequencer.sv
// ----------------------------------------------------------------------------
// frame_config_sequencer
// Turns a 32-bit configuration word stream into eFPGA frame writes. Waits for
// the sync word, then per frame parses a header (column/frame index), collects
// NumberOfRows+2 data words into FrameData and pulses one FrameStrobe bit.
//
// Ports
//   CLK          clock
//   resetn       asynchronous active-low reset
//   cfg          word stream (slave modport: s_data, s_valid in; s_ready out)
//   FrameData    assembled frame, word k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  one-hot write strobe, bit col*MaxFramesPerCol+frame
//   active       high from sync acceptance until desync or header error
//   error        sticky bad-header flag, cleared by the next sync
//   frame_count  strobes since last sync, saturating
//
// state  | meaning
// IDLE   | hunting for the sync word, everything else dropped
// HEADER | next accepted word is a frame header (or re-sync / desync)
// DATA   | collecting NumberOfRows+2 frame words
// STROBE | single cycle: FrameStrobe bit high, stream stalled
// ----------------------------------------------------------------------------
module frame_config_sequencer #(
  parameter int          NumberOfRows     = 16,
  parameter int          NumberOfCols     = 19,
  parameter int          FrameBitsPerRow  = 32,
  parameter int          MaxFramesPerCol  = 20,
  parameter int          FrameSelectWidth = 5,
  parameter int          RowSelectWidth   = 5,
  parameter int          DesyncFlag       = 20,
  parameter logic [31:0] SyncWord         = 32'hFAB0_FAB1
) (
  input  logic                                         CLK,
  input  logic                                         resetn,
  frame_config_sequencer_if.slave                      cfg,
  output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0]  FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0]      FrameStrobe,
  output logic                                         active,
  output logic                                         error,
  output logic [15:0]                                  frame_count
);

  localparam int STROBE_W = NumberOfCols * MaxFramesPerCol;
  localparam int IDX_W    = $clog2(STROBE_W);
  localparam int WORDS    = NumberOfRows + 2;

  localparam logic [RowSelectWidth-1:0]   LAST_ROW  = RowSelectWidth'(WORDS - 1);
  localparam logic [FrameSelectWidth-1:0] DESYNC    = FrameSelectWidth'(DesyncFlag);
  localparam logic [FrameSelectWidth-1:0] MAX_FRAME = FrameSelectWidth'(MaxFramesPerCol);
  localparam logic [4:0]                  NUM_COLS  = 5'(NumberOfCols);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic                        s_ready_q;
  logic [RowSelectWidth-1:0]   row;
  logic [IDX_W-1:0]            strobe_idx;

  logic                        accept;
  logic                        is_sync;
  logic                        is_desync;
  logic                        hdr_bad;
  logic [FrameSelectWidth-1:0] hdr_frame;
  logic [4:0]                  hdr_col;

  assign cfg.s_ready = s_ready_q;
  assign accept      = cfg.s_valid && s_ready_q;
  assign hdr_frame   = cfg.s_data[FrameSelectWidth-1:0];
  assign hdr_col     = cfg.s_data[12:8];
  assign is_sync     = (cfg.s_data == SyncWord);
  assign is_desync   = (hdr_frame == DESYNC);
  // Desync index is legal even though it lies beyond the last real frame.
  assign hdr_bad     = (!is_desync && (hdr_frame >= MAX_FRAME)) || (hdr_col >= NUM_COLS);

  // State register; s_ready is registered from the upcoming state so it is
  // already low during the STROBE cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      s_ready_q <= 1'b1;
    end else begin
      state     <= state_next;
      s_ready_q <= (state_next != STROBE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_sync) state_next = HEADER;
      end
      HEADER: begin
        if (accept) begin
          if (is_sync)        state_next = HEADER;
          else if (is_desync) state_next = IDLE;
          else if (hdr_bad)   state_next = IDLE;
          else                state_next = DATA;
        end
      end
      DATA: begin
        if (accept && (row == LAST_ROW)) state_next = STROBE;
      end
      STROBE: begin
        state_next = HEADER;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    FrameStrobe = '0;
    for (int b = 0; b < STROBE_W; b++) begin
      FrameStrobe[b] = (state == STROBE) && (strobe_idx == IDX_W'(b));
    end
  end

  // Frame datapath, header latch and status flags.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData   <= '0;
      row         <= '0;
      strobe_idx  <= '0;
      active      <= 1'b0;
      error       <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_sync) begin
            active      <= 1'b1;
            error       <= 1'b0;
            frame_count <= '0;
          end
        end
        HEADER: begin
          if (accept) begin
            if (is_sync) begin
              frame_count <= '0;
            end else if (is_desync) begin
              active <= 1'b0;
            end else if (hdr_bad) begin
              error  <= 1'b1;
              active <= 1'b0;
            end else begin
              strobe_idx <= IDX_W'(hdr_col) * IDX_W'(MaxFramesPerCol) + IDX_W'(hdr_frame);
              row        <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            for (int r = 0; r < WORDS; r++) begin
              if (row == RowSelectWidth'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= cfg.s_data;
              end
            end
            // Parks on the last row; HEADER reloads it for the next frame.
            if (row != LAST_ROW) row <= row + 1'b1;
          end
        end
        STROBE: begin
          if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
module tb_frame_config_sequencer;
  localparam int          NW   = 18;
  localparam int          FW   = 32 * NW;
  localparam int          SW   = 19 * 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK    = 1'b0;
  logic          resetn = 1'b0;
  logic [FW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          active;
  logic          error;
  logic [15:0]   frame_count;

  frame_config_sequencer_if cfg ();

  frame_config_sequencer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .cfg         (cfg),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .active      (active),
    .error       (error),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  // Strobe monitor: records the set bit of every strobe cycle.
  int strobe_q[$];
  int multi_hot = 0;
  int nready    = 0;
  always @(negedge CLK) begin
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    for (int b = 0; b < SW; b++) begin
      if (FrameStrobe[b]) begin
        cnt++;
        idx = b;
      end
    end
    if (cnt > 0) strobe_q.push_back(idx);
    if (cnt > 1) multi_hot++;
    if (!cfg.s_ready) nready++;
  end

  logic [FW-1:0] exp_fd;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] base;
    logic        exp_active;
    logic        exp_error;
    int          exp_bit;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic chk_fd(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    cfg.s_data  = w;
    cfg.s_valid = 1'b1;
    while (!cfg.s_ready && n < 8) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!cfg.s_ready) begin
      total++;
      $display("FAIL send_timeout actual=ready_low required=ready_high word=%h", w);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    cfg.s_valid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int k = 0; k < NW; k++) begin
      send(base + 32'(k));
      exp_fd[k*32 +: 32] = base + 32'(k);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0307, 32'h0000_0100, 1'b1, 1'b0, 67};
    vecs[1] = '{32'h0000_0014, 32'h0000_0000, 1'b0, 1'b0, -1};
    vecs[2] = '{32'h0000_1300, 32'h0000_0000, 1'b0, 1'b1, -1};
    vecs[3] = '{32'h0000_1213, 32'h0003_0000, 1'b1, 1'b0, 379};
    vecs[4] = '{32'h0000_0015, 32'h0000_0000, 1'b0, 1'b1, -1};
    vecs[5] = '{32'hFFFF_E005, 32'h0005_0000, 1'b1, 1'b0, 5};
    vecs[6] = '{32'h0000_001F, 32'h0000_0000, 1'b0, 1'b1, -1};
    vecs[7] = '{32'h0000_0A0C, 32'h0007_0000, 1'b1, 1'b0, 212};

    exp_fd      = '0;
    cfg.s_data  = '0;
    cfg.s_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", cfg.s_ready, 1);
    chk("rst_active", active, 0);
    chk("rst_error", error, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_strobe", 64'(FrameStrobe != '0), 0);
    chk_fd("rst_data", FrameData, '0);
    resetn = 1'b1;
    idle(1);

    // Non-sync words in IDLE are dropped.
    send(32'h0000_0307);
    send(32'h1234_5678);
    idle(1);
    chk("idle_ignore_active", active, 0);

    // Header table.
    for (int v = 0; v < 8; v++) begin
      send(SYNC);
      idle(1);
      chk($sformatf("v%0d_sync_active", v), active, 1);
      chk($sformatf("v%0d_sync_error", v), error, 0);
      chk($sformatf("v%0d_sync_count", v), frame_count, 0);
      send(vecs[v].hdr);
      idle(1);
      chk($sformatf("v%0d_hdr_active", v), active, 64'(vecs[v].exp_active));
      chk($sformatf("v%0d_hdr_error", v), error, 64'(vecs[v].exp_error));
      strobe_q.delete();
      if (vecs[v].exp_bit >= 0) begin
        send_frame(vecs[v].base);
        chk($sformatf("v%0d_strobe_bit", v), 64'(FrameStrobe[vecs[v].exp_bit]), 1);
        chk($sformatf("v%0d_strobe_ready", v), cfg.s_ready, 0);
        idle(1);
        chk($sformatf("v%0d_strobe_off", v), 64'(FrameStrobe != '0), 0);
        chk($sformatf("v%0d_count", v), frame_count, 1);
        chk_fd($sformatf("v%0d_data", v), FrameData, exp_fd);
        chk($sformatf("v%0d_nstrobe", v), strobe_q.size(), 1);
        if (strobe_q.size() == 1) chk($sformatf("v%0d_idx", v), strobe_q[0], vecs[v].exp_bit);
      end else begin
        // Now in IDLE: a well-formed header and frame must be ignored.
        send(32'h0000_0307);
        for (int k = 0; k < NW; k++) send(32'h0009_0000 + 32'(k));
        idle(1);
        chk($sformatf("v%0d_no_strobe", v), strobe_q.size(), 0);
        chk($sformatf("v%0d_idle_active", v), active, 0);
        chk($sformatf("v%0d_idle_error", v), error, 64'(vecs[v].exp_error));
        chk_fd($sformatf("v%0d_data_kept", v), FrameData, exp_fd);
      end
    end

    // Back-to-back frames with s_valid held high.
    begin
      int n0;
      send(SYNC);
      strobe_q.delete();
      n0 = nready;
      send(32'h0000_0000);
      send_frame(32'h000A_0000);
      send(32'h0000_1213);
      send_frame(32'h000B_0000);
      idle(2);
      chk("b2b_nstrobe", strobe_q.size(), 2);
      if (strobe_q.size() == 2) begin
        chk("b2b_idx0", strobe_q[0], 0);
        chk("b2b_idx1", strobe_q[1], 379);
      end
      chk("b2b_ready_low", nready - n0, 2);
      chk("b2b_count", frame_count, 2);
      chk_fd("b2b_data", FrameData, exp_fd);
    end

    // Random gaps during DATA, sync value as word 5.
    send(SYNC);
    send(32'h0000_0307);
    strobe_q.delete();
    for (int k = 0; k < NW; k++) begin
      logic [31:0] w;
      w = (k == 5) ? SYNC : 32'h0000_0100 + 32'(k);
      idle($urandom_range(0, 3));
      send(w);
      exp_fd[k*32 +: 32] = w;
    end
    chk("gap_strobe_bit", 64'(FrameStrobe[67]), 1);
    chk("gap_strobe_ready", cfg.s_ready, 0);
    idle(1);
    chk_fd("gap_data", FrameData, exp_fd);
    chk("gap_slice5", FrameData[5*32 +: 32], SYNC);
    chk("gap_nstrobe", strobe_q.size(), 1);
    if (strobe_q.size() == 1) chk("gap_idx", strobe_q[0], 67);
    chk("gap_count", frame_count, 1);

    // Reset in the middle of a frame.
    send(SYNC);
    send(32'h0000_0307);
    strobe_q.delete();
    for (int k = 0; k < 9; k++) send(32'h0000_0C00 + 32'(k));
    idle(0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_ready", cfg.s_ready, 1);
    chk("mrst_active", active, 0);
    chk("mrst_error", error, 0);
    chk("mrst_count", frame_count, 0);
    chk("mrst_strobe", 64'(FrameStrobe != '0), 0);
    chk_fd("mrst_data", FrameData, '0);
    @(posedge CLK);
    #1;
    resetn = 1'b1;
    send(32'h0000_0307);
    for (int k = 0; k < NW; k++) send(32'h0000_0D00 + 32'(k));
    idle(2);
    chk("mrst_no_strobe", strobe_q.size(), 0);
    chk("mrst_after_active", active, 0);
    chk_fd("mrst_after_data", FrameData, '0);

    chk("onehot", multi_hot, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
